// File: rtl/tlul_mem_responder.sv
// TL-UL device adapter for a simple single-port memory.
// Checks each A beat, issues a memory request for legal ones, and returns
// D responses in A-acceptance order. Illegal requests are answered without
// touching memory, but they still wait behind earlier memory responses.

package tlul_pkg;

   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic [6:0] cmd_intg;
      logic [6:0] data_intg;
   } tl_a_user_t;

   typedef struct packed {
      logic [6:0] rsp_intg;
      logic [6:0] data_intg;
   } tl_d_user_t;

   localparam tl_a_user_t TL_A_USER_DEFAULT = '{cmd_intg: '0, data_intg: '0};
   localparam tl_d_user_t TL_D_USER_DEFAULT = '{rsp_intg: '0, data_intg: '0};

   typedef struct packed {
      logic         a_valid;
      logic [2:0]   a_opcode;
      logic [2:0]   a_param;
      logic [1:0]   a_size;
      logic [7:0]   a_source;
      logic [31:0]  a_address;
      logic [3:0]   a_mask;
      logic [31:0]  a_data;
      tl_a_user_t   a_user;
      logic         d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic         d_valid;
      logic [2:0]   d_opcode;
      logic [2:0]   d_param;
      logic [1:0]   d_size;
      logic [7:0]   d_source;
      logic [0:0]   d_sink;
      logic [31:0]  d_data;
      tl_d_user_t   d_user;
      logic         d_error;
      logic         a_ready;
   } tl_d2h_t;

endpackage

module tlul_mem_responder #(
   parameter int unsigned AW          = 14,
   parameter int unsigned Outstanding = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  tlul_pkg::tl_h2d_t tl_i,
   output tlul_pkg::tl_d2h_t tl_o,
   output logic              req_o,
   output logic              we_o,
   output logic [AW-1:0]     addr_o,
   output logic [31:0]       wdata_o,
   output logic [3:0]        be_o,
   input  logic              gnt_i,
   input  logic              rvalid_i,
   input  logic [31:0]       rdata_i,
   input  logic              rerror_i
);
   import tlul_pkg::*;

   localparam int unsigned PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
   localparam int unsigned CW = $clog2(Outstanding + 1);

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] size;
      logic [7:0] source;
      logic       err;
      logic       bypass;
   } trk_t;

   typedef struct packed {
      logic [31:0] data;
      logic        error;
   } rsp_t;

   trk_t          trk_mem [Outstanding];
   logic [PW-1:0] trk_wptr, trk_rptr;
   logic [CW-1:0] trk_cnt;

   rsp_t          buf_mem [Outstanding];
   logic [PW-1:0] buf_wptr, buf_rptr;
   logic [CW-1:0] buf_cnt;

   // granted memory requests still waiting for their rvalid_i
   logic [CW-1:0] mem_pend;
   logic          proto_err;

   logic [3:0]    lane;
   logic          a_err, slot_free, a_ready, a_acc, mem_acc;
   logic          d_valid, d_acc, buf_push, buf_pop;
   trk_t          head, entry;
   rsp_t          rhead;

   logic          unused_a;
   assign unused_a = ^{tl_i.a_param, tl_i.a_user};

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (32'(p) == Outstanding - 1) ? '0 : p + 1'b1;
   endfunction

   // request legality: opcode, size, alignment, lane mask and address range
   always_comb begin
      case (tl_i.a_size)
         2'd0:    lane = 4'b0001 << tl_i.a_address[1:0];
         2'd1:    lane = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
         default: lane = 4'b1111;
      endcase
      a_err = 1'b0;
      if (!(tl_i.a_opcode inside {Get, PutFullData, PutPartialData})) a_err = 1'b1;
      if (tl_i.a_size == 2'd3) a_err = 1'b1;
      if (tl_i.a_size == 2'd1 && tl_i.a_address[0]) a_err = 1'b1;
      if (tl_i.a_size == 2'd2 && (|tl_i.a_address[1:0])) a_err = 1'b1;
      if (|(tl_i.a_mask & ~lane)) a_err = 1'b1;
      if (tl_i.a_opcode == PutFullData && tl_i.a_mask != lane) a_err = 1'b1;
      if (|tl_i.a_address[31:AW+2]) a_err = 1'b1;
   end

   assign slot_free = 32'(trk_cnt) < Outstanding;
   assign req_o     = tl_i.a_valid & ~a_err & slot_free;
   assign we_o      = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);
   assign addr_o    = tl_i.a_address[AW+1:2];
   assign wdata_o   = tl_i.a_data;
   assign be_o      = tl_i.a_mask;
   assign a_ready   = slot_free & (a_err | gnt_i);
   assign a_acc     = tl_i.a_valid & a_ready;
   assign mem_acc   = req_o & gnt_i;

   assign head      = trk_mem[trk_rptr];
   assign rhead     = buf_mem[buf_rptr];
   assign d_valid   = (trk_cnt != '0) & (head.bypass | (buf_cnt != '0));
   assign d_acc     = d_valid & tl_i.d_ready;
   assign buf_push  = rvalid_i & (mem_pend != '0);
   assign buf_pop   = d_acc & ~head.bypass;

   // tracking entry built from the current A beat
   always_comb begin
      entry        = '0;
      entry.op     = (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
      entry.size   = tl_i.a_size;
      entry.source = tl_i.a_source;
      entry.err    = a_err;
      entry.bypass = a_err;
   end

   // D channel driven purely from the FIFO heads, so it holds while stalled
   always_comb begin
      tl_o          = '0;
      tl_o.a_ready  = a_ready;
      tl_o.d_valid  = d_valid;
      tl_o.d_opcode = head.op;
      tl_o.d_param  = '0;
      tl_o.d_size   = head.size;
      tl_o.d_source = head.source;
      tl_o.d_sink   = '0;
      tl_o.d_user   = TL_D_USER_DEFAULT;
      tl_o.d_error  = head.err | (~head.bypass & rhead.error);
      if (head.op == AccessAckData) begin
         tl_o.d_data = head.err ? '1 : rhead.data;
      end else begin
         tl_o.d_data = '0;
      end
   end

   // storage arrays, written only at in-range pointer positions
   always_ff @(posedge clk_i) begin
      if (a_acc)    trk_mem[trk_wptr] <= entry;
      if (buf_push) buf_mem[buf_wptr] <= '{data: rdata_i, error: rerror_i};
   end

   // pointers, occupancy counters and protocol sticky flag
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         trk_wptr  <= '0;
         trk_rptr  <= '0;
         trk_cnt   <= '0;
         buf_wptr  <= '0;
         buf_rptr  <= '0;
         buf_cnt   <= '0;
         mem_pend  <= '0;
         proto_err <= 1'b0;
      end else begin
         if (a_acc)    trk_wptr <= ptr_inc(trk_wptr);
         if (d_acc)    trk_rptr <= ptr_inc(trk_rptr);
         if (buf_push) buf_wptr <= ptr_inc(buf_wptr);
         if (buf_pop)  buf_rptr <= ptr_inc(buf_rptr);
         trk_cnt   <= trk_cnt + CW'(a_acc) - CW'(d_acc);
         buf_cnt   <= buf_cnt + CW'(buf_push) - CW'(buf_pop);
         mem_pend  <= mem_pend + CW'(mem_acc) - CW'(buf_push);
         proto_err <= proto_err | (rvalid_i & (mem_pend == '0));
      end
   end

   // once raised, the protocol flag stays up until reset
   assert property (@(posedge clk_i)
      (rst_ni && $past(rst_ni) && $past(proto_err)) |-> proto_err);

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Directed bench for tlul_mem_responder with a one-cycle memory model.

module tb_tlul_mem_responder;
   import tlul_pkg::*;

   localparam int unsigned AW = 14;

   logic          clk = 1'b0;
   logic          rst_n;
   tl_h2d_t       tl_h;
   tl_d2h_t       tl_d;
   logic          req, we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [3:0]    be;
   logic          gnt, rvalid, rerror;
   logic [31:0]   rdata;
   logic          mem_auto;

   int unsigned   n_vec = 0;
   int unsigned   n_bad = 0;

   always #5 clk = ~clk;

   tlul_mem_responder #(.AW(AW), .Outstanding(2)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .tl_i     (tl_h),
      .tl_o     (tl_d),
      .req_o    (req),
      .we_o     (we),
      .addr_o   (addr),
      .wdata_o  (wdata),
      .be_o     (be),
      .gnt_i    (gnt),
      .rvalid_i (rvalid),
      .rdata_i  (rdata),
      .rerror_i (rerror)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
      return (a == 14'd4) ? 32'hDEAD_BEEF : {16'hA500, 2'b00, a};
   endfunction

   // one clock; in auto mode a grant seen before the edge returns rvalid next cycle
   task automatic tick();
      logic          fire, fwe;
      logic [AW-1:0] fa;
      #1;
      fire = req & gnt;
      fwe  = we;
      fa   = addr;
      @(posedge clk);
      #1;
      if (mem_auto) begin
         rvalid = fire;
         rdata  = (fire && !fwe) ? mem_rd(fa) : 32'h0;
         rerror = 1'b0;
      end
   endtask

   task automatic drive_a(input logic v, input logic [2:0] op, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [3:0] m,
                          input logic [31:0] dat, input logic [7:0] src);
      tl_h.a_valid   = v;
      tl_h.a_opcode  = op;
      tl_h.a_param   = 3'h0;
      tl_h.a_size    = sz;
      tl_h.a_address = ad;
      tl_h.a_mask    = m;
      tl_h.a_data    = dat;
      tl_h.a_source  = src;
      tl_h.a_user    = TL_A_USER_DEFAULT;
   endtask

   task automatic check_d(input string tag, input logic [2:0] op, input logic [1:0] sz,
                          input logic [7:0] src, input logic [31:0] dat, input logic err);
      #1;
      check({tag, ".valid"},  32'(tl_d.d_valid),  32'h1);
      check({tag, ".opcode"}, 32'(tl_d.d_opcode), 32'(op));
      check({tag, ".size"},   32'(tl_d.d_size),   32'(sz));
      check({tag, ".source"}, 32'(tl_d.d_source), 32'(src));
      check({tag, ".data"},   tl_d.d_data,        dat);
      check({tag, ".error"},  32'(tl_d.d_error),  32'(err));
   endtask

   // legality decode seen through a_ready with gnt low and no A valid
   task automatic chk_err(input string tag, input logic [2:0] op, input logic [1:0] sz,
                          input logic [31:0] ad, input logic [3:0] m, input logic e);
      drive_a(1'b0, op, sz, ad, m, 32'h0, 8'h0);
      #1;
      check(tag, 32'(tl_d.a_ready), 32'(e));
   endtask

   initial begin
      rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; rerror = 1'b0; mem_auto = 1'b1;
      tl_h = '0;
      tl_h.d_ready = 1'b1;
      drive_a(1'b0, Get, 2'd2, 32'h0, 4'hF, 32'h0, 8'h0);
      tick(); tick();

      // reset state
      #1;
      check("rst.d_valid", 32'(tl_d.d_valid), 32'h0);
      check("rst.req",     32'(req),          32'h0);
      check("rst.a_ready", 32'(tl_d.a_ready), 32'h0);
      drive_a(1'b0, Get, 2'd3, 32'h0, 4'hF, 32'h0, 8'h0);
      #1;
      check("rst.a_ready_err", 32'(tl_d.a_ready), 32'h1);
      check("rst.d_param", 32'(tl_d.d_param), 32'h0);
      check("rst.d_sink",  32'(tl_d.d_sink),  32'h0);
      rst_n = 1'b1;

      // legality table
      chk_err("err.get_w0",     Get,            2'd2, 32'h0000_0000, 4'hF, 1'b0);
      chk_err("err.get_h2_lo",  Get,            2'd1, 32'h0000_0002, 4'h3, 1'b1);
      chk_err("err.get_h2_hi",  Get,            2'd1, 32'h0000_0002, 4'hC, 1'b0);
      chk_err("err.get_b1",     Get,            2'd0, 32'h0000_0001, 4'h2, 1'b0);
      chk_err("err.get_b1_bad", Get,            2'd0, 32'h0000_0001, 4'h1, 1'b1);
      chk_err("err.pfull_w7",   PutFullData,    2'd2, 32'h0000_0000, 4'h7, 1'b1);
      chk_err("err.pfull_h",    PutFullData,    2'd1, 32'h0000_0002, 4'hC, 1'b0);
      chk_err("err.ppart_m0",   PutPartialData, 2'd2, 32'h0000_0000, 4'h0, 1'b0);
      chk_err("err.size3",      Get,            2'd3, 32'h0000_0000, 4'hF, 1'b1);
      chk_err("err.op2",        3'd2,           2'd2, 32'h0000_0000, 4'hF, 1'b1);
      chk_err("err.op7",        3'd7,           2'd2, 32'h0000_0000, 4'hF, 1'b1);
      chk_err("err.addr_hi",    Get,            2'd2, 32'h0001_0000, 4'hF, 1'b1);
      chk_err("err.addr_top",   Get,            2'd2, 32'h0000_FFFC, 4'hF, 1'b0);
      chk_err("err.mis_h",      Get,            2'd1, 32'h0000_0001, 4'h3, 1'b1);
      chk_err("err.mis_w",      Get,            2'd2, 32'h0000_0002, 4'hF, 1'b1);
      gnt = 1'b1;
      tick();

      // Get 0x10 -> DEADBEEF two cycles after acceptance
      drive_a(1'b1, Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'd3);
      #1;
      check("get.req",     32'(req),          32'h1);
      check("get.we",      32'(we),           32'h0);
      check("get.addr",    32'(addr),         32'h4);
      check("get.a_ready", 32'(tl_d.a_ready), 32'h1);
      tick();
      tl_h.a_valid = 1'b0;
      #1;
      check("get.n1_d_valid", 32'(tl_d.d_valid), 32'h0);
      tick();
      check_d("get.n2", AccessAckData, 2'd2, 8'd3, 32'hDEAD_BEEF, 1'b0);
      check("get.d_param", 32'(tl_d.d_param), 32'h0);
      tick();
      #1;
      check("get.done", 32'(tl_d.d_valid), 32'h0);

      // PutPartialData 0x22 mask C
      drive_a(1'b1, PutPartialData, 2'd1, 32'h22, 4'hC, 32'h1234_5678, 8'd5);
      #1;
      check("ppart.req",   32'(req),  32'h1);
      check("ppart.we",    32'(we),   32'h1);
      check("ppart.be",    32'(be),   32'hC);
      check("ppart.addr",  32'(addr), 32'h8);
      check("ppart.wdata", wdata,     32'h1234_5678);
      tick();
      tl_h.a_valid = 1'b0;
      #1;
      check("ppart.n1_d_valid", 32'(tl_d.d_valid), 32'h0);
      tick();
      check_d("ppart.n2", AccessAck, 2'd1, 8'd5, 32'h0, 1'b0);
      tick();

      // misaligned Get bypasses memory, answered next cycle
      drive_a(1'b1, Get, 2'd2, 32'h3, 4'hF, 32'h0, 8'd7);
      #1;
      check("mis.req",     32'(req),          32'h0);
      check("mis.a_ready", 32'(tl_d.a_ready), 32'h1);
      tick();
      tl_h.a_valid = 1'b0;
      check_d("mis.n1", AccessAckData, 2'd2, 8'd7, 32'hFFFF_FFFF, 1'b1);
      tick();
      #1;
      check("mis.done", 32'(tl_d.d_valid), 32'h0);

      // three Gets with D stalled: the third waits for a slot
      tl_h.d_ready = 1'b0;
      drive_a(1'b1, Get, 2'd2, 32'h20, 4'hF, 32'h0, 8'd1);
      #1;
      check("bp.a1_ready", 32'(tl_d.a_ready), 32'h1);
      tick();
      drive_a(1'b1, Get, 2'd2, 32'h24, 4'hF, 32'h0, 8'd2);
      #1;
      check("bp.a2_ready", 32'(tl_d.a_ready), 32'h1);
      tick();
      drive_a(1'b1, Get, 2'd2, 32'h28, 4'hF, 32'h0, 8'd3);
      #1;
      check("bp.a3_block", 32'(tl_d.a_ready), 32'h0);
      check("bp.a3_noreq", 32'(req),          32'h0);
      check_d("bp.stall0", AccessAckData, 2'd2, 8'd1, 32'hA500_0008, 1'b0);
      tick();
      check_d("bp.stall1", AccessAckData, 2'd2, 8'd1, 32'hA500_0008, 1'b0);
      tl_h.d_ready = 1'b1;
      #1;
      check("bp.a3_still", 32'(tl_d.a_ready), 32'h0);
      tick();
      #1;
      check("bp.a3_ready", 32'(tl_d.a_ready), 32'h1);
      check_d("bp.d2", AccessAckData, 2'd2, 8'd2, 32'hA500_0009, 1'b0);
      tick();
      tl_h.a_valid = 1'b0;
      #1;
      check("bp.gap", 32'(tl_d.d_valid), 32'h0);
      tick();
      check_d("bp.d3", AccessAckData, 2'd2, 8'd3, 32'hA500_000A, 1'b0);
      tick();

      // illegal opcode queued behind a slow read
      mem_auto = 1'b0;
      rvalid = 1'b0;
      drive_a(1'b1, Get, 2'd2, 32'h0, 4'hF, 32'h0, 8'd4);
      tick();
      drive_a(1'b1, 3'd7, 2'd2, 32'h0, 4'hF, 32'h0, 8'd9);
      #1;
      check("ord.err_ready", 32'(tl_d.a_ready), 32'h1);
      check("ord.err_noreq", 32'(req),          32'h0);
      tick();
      tl_h.a_valid = 1'b0;
      #1;
      check("ord.wait", 32'(tl_d.d_valid), 32'h0);
      rvalid = 1'b1;
      rdata  = 32'h0BAD_F00D;
      tick();
      rvalid = 1'b0;
      check_d("ord.read", AccessAckData, 2'd2, 8'd4, 32'h0BAD_F00D, 1'b0);
      tick();
      check_d("ord.err", AccessAck, 2'd2, 8'd9, 32'h0, 1'b1);
      tick();
      #1;
      check("ord.done", 32'(tl_d.d_valid), 32'h0);

      // reset with two reads outstanding; late completions are ignored
      drive_a(1'b1, Get, 2'd2, 32'h30, 4'hF, 32'h0, 8'd1);
      tick();
      drive_a(1'b1, Get, 2'd2, 32'h34, 4'hF, 32'h0, 8'd2);
      #1;
      check("rr.a2_ready", 32'(tl_d.a_ready), 32'h1);
      tick();
      tl_h.a_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      check("rr.d_valid", 32'(tl_d.d_valid), 32'h0);
      check("rr.a_ready", 32'(tl_d.a_ready), 32'h1);
      rvalid = 1'b1;
      rdata  = 32'h1111_1111;
      tick();
      #1;
      check("rr.late0", 32'(tl_d.d_valid), 32'h0);
      tick();
      rvalid = 1'b0;
      #1;
      check("rr.late1", 32'(tl_d.d_valid), 32'h0);
      mem_auto = 1'b1;
      drive_a(1'b1, Get, 2'd2, 32'h10, 4'hF, 32'h0, 8'd6);
      tick();
      tl_h.a_valid = 1'b0;
      #1;
      check("rr.new_n1", 32'(tl_d.d_valid), 32'h0);
      tick();
      check_d("rr.new", AccessAckData, 2'd2, 8'd6, 32'hDEAD_BEEF, 1'b0);
      tick();
      #1;
      check("rr.done", 32'(tl_d.d_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
